// File: rtl/genreg_controller.sv
// genreg_controller: launches one generic-register bus read/write per GO rising edge, with req/ack handshake and timeout.
module genreg_controller #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [31:0]           genreg_addr_ctrl,
  input  logic [31:0]           genreg_wr_data,
  output logic [31:0]           genreg_rd_data,
  output logic [31:0]           genreg_status,
  output logic [ADDR_WIDTH-1:0] gr_addr,
  output logic [31:0]           gr_wdata,
  output logic                  gr_we,
  output logic                  gr_req,
  input  logic [31:0]           gr_rdata,
  input  logic                  gr_ack
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, REQ} state_e;
  state_e                state_q;
  logic                  go_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           rd_q;
  logic                  we_q;
  logic                  req_q;
  logic                  done_q;
  logic                  to_q;
  logic                  ovr_q;
  logic                  go_edge;
  logic                  last;
  logic                  unused_ctrl;
  assign go_edge     = genreg_addr_ctrl[31] & ~go_q;
  assign last        = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign unused_ctrl = ^genreg_addr_ctrl[29:ADDR_WIDTH];
  // go_q resets high so a GO already asserted at reset release is not an edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      go_q    <= 1'b1;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      go_q <= genreg_addr_ctrl[31];
      if (state_q == IDLE) begin
        if (go_edge) begin
          addr_q  <= genreg_addr_ctrl[ADDR_WIDTH-1:0];
          we_q    <= genreg_addr_ctrl[30];
          wdata_q <= genreg_wr_data;
          done_q  <= 1'b0;
          to_q    <= 1'b0;
          ovr_q   <= 1'b0;
          req_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= REQ;
        end
      end else begin
        if (go_edge) ovr_q <= 1'b1;
        if (gr_ack) begin
          req_q   <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
          if (!we_q) rd_q <= gr_rdata;
        end else if (last) begin
          req_q   <= 1'b0;
          done_q  <= 1'b1;
          to_q    <= 1'b1;
          state_q <= IDLE;
          if (!we_q) rd_q <= 32'hFFFF_FFFF;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end
  assign genreg_rd_data = rd_q;
  assign genreg_status  = {28'b0, ovr_q, to_q, done_q, req_q};
  assign gr_addr        = addr_q;
  assign gr_wdata       = wdata_q;
  assign gr_we          = we_q;
  assign gr_req         = req_q;
endmodule

// File: tb/tb_genreg_controller.sv
// tb_genreg_controller: randomized scoreboard bench; driver queues expected outcomes, monitor checks each req window.
module tb_genreg_controller;
  localparam int T = 8;
  logic        clk = 0;
  logic        reset_n;
  logic [31:0] genreg_addr_ctrl, genreg_wr_data, genreg_rd_data, genreg_status;
  logic [15:0] gr_addr;
  logic [31:0] gr_wdata, gr_rdata;
  logic        gr_we, gr_req, gr_ack;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
    logic [31:0] rd;
    logic [31:0] st;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] rd_m = 0;
  logic [31:0] st_m = 0;
  genreg_controller #(.ADDR_WIDTH(16), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .genreg_addr_ctrl(genreg_addr_ctrl),
    .genreg_wr_data(genreg_wr_data), .genreg_rd_data(genreg_rd_data),
    .genreg_status(genreg_status), .gr_addr(gr_addr), .gr_wdata(gr_wdata),
    .gr_we(gr_we), .gr_req(gr_req), .gr_rdata(gr_rdata), .gr_ack(gr_ack)
  );
  always #4 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // monitor: one scoreboard entry per window in which gr_req was high
  logic        prev_req = 0;
  int          len_c = 0;
  logic [15:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;
  always @(negedge clk) begin
    if (gr_req && !prev_req) begin
      len_c = 1;
      cap_addr = gr_addr;
      cap_we = gr_we;
      cap_wdata = gr_wdata;
    end else if (gr_req) len_c++;
    if (!gr_req && prev_req) begin
      if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("addr", {16'b0, cap_addr}, {16'b0, e.addr});
        chk("we", {31'b0, cap_we}, {31'b0, e.we});
        chk("wdata", cap_wdata, e.wdata);
        chk("req_len", len_c, e.len);
        chk("rd_data", genreg_rd_data, e.rd);
        chk("status", genreg_status, e.st);
      end
    end
    prev_req = gr_req;
  end
  // ack_at: req cycle carrying ack (0 = never); ovr_at: req cycle re-raising GO; rst_at: req cycle asserting reset
  task automatic txn(input logic [15:0] a, input logic we, input logic [31:0] wd,
                     input int ack_at, input logic [31:0] rdat, input int ovr_at, input int rst_at);
    exp_t e;
    int len;
    len = rst_at != 0 ? rst_at : (ack_at != 0 ? ack_at : T);
    e.addr = a;
    e.we = we;
    e.wdata = wd;
    e.len = len;
    if (rst_at != 0) begin
      e.rd = 0;
      e.st = 0;
    end else begin
      e.rd = we ? rd_m : (ack_at != 0 ? rdat : 32'hFFFF_FFFF);
      e.st = (ack_at != 0 ? 32'h2 : 32'h6) | (ovr_at != 0 ? 32'h8 : 32'h0);
    end
    exp_q.push_back(e);
    rd_m = e.rd;
    st_m = e.st;
    genreg_addr_ctrl = {1'b1, we, 14'($urandom), a};
    genreg_wr_data = wd;
    cyc();
    for (int k = 1; k <= len; k++) begin
      if (k == 1) genreg_addr_ctrl[31] = 1'b0;
      if (k == ovr_at) begin
        genreg_addr_ctrl = {1'b1, ~we, 14'($urandom), ~a};
        genreg_wr_data = ~wd;
      end
      if (k == rst_at) reset_n = 1'b0;
      gr_ack = (k == ack_at);
      gr_rdata = (k == ack_at) ? rdat : $urandom;
      cyc();
    end
    gr_ack = 0;
    genreg_addr_ctrl[31] = 1'b0;
    cyc();
    cyc();
  endtask
  initial begin
    reset_n = 0;
    genreg_addr_ctrl = 32'h8000_0000;
    genreg_wr_data = 0;
    gr_rdata = 0;
    gr_ack = 0;
    repeat (3) cyc();
    chk("rst_status", genreg_status, 0);
    chk("rst_req", {31'b0, gr_req}, 0);
    chk("rst_rd", genreg_rd_data, 0);
    chk("rst_addr", {16'b0, gr_addr}, 0);
    chk("rst_wdata", gr_wdata, 0);
    chk("rst_we", {31'b0, gr_we}, 0);
    reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("go_held_req", {31'b0, gr_req}, 0);
      chk("go_held_status", genreg_status, 0);
    end
    genreg_addr_ctrl[31] = 0;
    cyc();
    txn(16'h0012, 0, 32'h0, 3, 32'hCAFE_F00D, 0, 0);
    txn(16'h0034, 1, 32'h1234_5678, 1, 32'h0, 0, 0);
    txn(16'h0056, 0, 32'h0, 0, 32'h0, 0, 0);
    txn(16'h0078, 0, 32'h0, T, 32'hA5A5_1234, 0, 0);
    txn(16'h009A, 0, 32'h0, 5, 32'h0BAD_BEEF, 2, 0);
    txn(16'h00BC, 1, 32'hDEAD_0001, 2, 32'h0, 0, 0);
    gr_ack = 1;
    gr_rdata = 32'h7777_7777;
    cyc();
    gr_ack = 0;
    chk("stray_ack_req", {31'b0, gr_req}, 0);
    chk("stray_ack_rd", genreg_rd_data, rd_m);
    chk("stray_ack_status", genreg_status, st_m);
    for (int i = 0; i < 24; i++) begin
      int ack_at, ovr_at;
      ack_at = $urandom_range(0, T);
      ovr_at = 0;
      if ($urandom_range(0, 3) == 0) begin
        if (ack_at == 0) ovr_at = $urandom_range(2, T);
        else if (ack_at >= 2) ovr_at = $urandom_range(2, ack_at);
      end
      txn(16'($urandom), 1'($urandom), $urandom, ack_at, $urandom, ovr_at, 0);
    end
    txn(16'h0101, 0, 32'h0, 0, 32'h0, 0, 2);
    genreg_addr_ctrl[31] = 1;
    cyc();
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      gr_ack = 1;
      gr_rdata = 32'h5555_AAAA;
      cyc();
      chk("late_ack_req", {31'b0, gr_req}, 0);
      chk("late_ack_status", genreg_status, 0);
      chk("late_ack_rd", genreg_rd_data, 0);
    end
    gr_ack = 0;
    genreg_addr_ctrl[31] = 0;
    cyc();
    txn(16'h0202, 0, 32'h0, 4, 32'h1357_9BDF, 0, 0);
    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
